// File: rtl/seq_multiplier_16x16_pkg.sv
// Shared types and constants for the
// shift-and-add multiplier.
package seq_multiplier_16x16_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Product width for a given operand width.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/seq_multiplier_16x16_datapath.sv
// Operand shift registers, accumulator and adder
// for the shift-and-add multiplier.
module mult_datapath
  import seq_multiplier_16x16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int PW = prod_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [PW-1:0]    sum
);

  logic [PW-1:0]    mcd;
  logic [WIDTH-1:0] mlr;
  logic [PW-1:0]    acc;

  // Accumulator plus multiplicand when the current
  // multiplier bit is set; also the final result on
  // the last step.
  always_comb begin
    sum = acc;
    if (mlr[0]) sum = acc + mcd;
  end

  // Load operands on acceptance, then consume one
  // multiplier bit per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcd <= '0;
      mlr <= '0;
      acc <= '0;
    end else if (load) begin
      mcd <= PW'(a);
      mlr <= b;
      acc <= '0;
    end else if (step) begin
      acc <= sum;
      mcd <= mcd << 1;
      mlr <= mlr >> 1;
    end
  end

endmodule

// File: rtl/seq_multiplier_16x16.sv
// Sequential unsigned multiplier: control FSM,
// iteration counter and registered product.
module seq_multiplier_16x16
  import seq_multiplier_16x16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int PW = prod_w(WIDTH),
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             reg_load,
  output logic [PW-1:0]    product
);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          load;
  logic          step;
  logic          last;
  logic [PW-1:0] sum;

  assign load = (state == IDLE) && start;
  assign step = (state == RUN);
  assign last = step && (cnt == CW'(WIDTH - 1));

  mult_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .step (step),
    .a    (a),
    .b    (b),
    .sum  (sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Status outputs decoded from registered state.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    reg_load = 1'b0;
    unique case (state)
      IDLE: ;
      RUN:  busy = 1'b1;
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        reg_load = 1'b1;
      end
      default: ;
    endcase
  end

  // Iteration counter, cleared on every acceptance.
  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + 1'b1;
  end

  // Product only ever takes a completed result.
  always_ff @(posedge clk) begin
    if (reset)     product <= '0;
    else if (last) product <= sum;
  end

endmodule

// File: tb/tb_seq_multiplier_16x16.sv
// Directed self-checking bench for the
// sequential multiplier with a result scoreboard.
module tb_seq_multiplier_16x16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        reg_load;
  logic [31:0] product;

  logic [31:0] dreg = '0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb[$];

  seq_multiplier_16x16 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .reg_load(reg_load),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream 32-bit enabled register.
  always @(posedge clk) if (reg_load) dreg <= product;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop_exp();
    logic [31:0] v;
    v = 32'hDEAD_BEEF;
    if (sb.size() > 0) v = sb.pop_front();
    return v;
  endfunction

  // Returns the cycle at which done is seen,
  // bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(output int at);
    bit got;
    got = 1'b0;
    at = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        at = cyc;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  task automatic op(input logic [15:0] x,
                    input logic [15:0] y);
    int e;
    int t;
    logic [31:0] ex;
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(32'(x) * 32'(y));
    @(posedge clk);
    #1;
    start = 1'b0;
    e = cyc;
    @(negedge clk);
    chk("busy_run", 32'(busy), 32'd1);
    chk("done_run", 32'(done), 32'd0);
    wait_done(t);
    ex = pop_exp();
    chk("latency", 32'(t - e), 32'd16);
    chk("product", product, ex);
    chk("reg_load", 32'(reg_load), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_low", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("dreg", dreg, ex);
  endtask

  initial begin
    int e;
    int t1;
    int t2;
    logic [31:0] ex;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;

    // 1: reset and idle quiet period
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_product", product, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_reg_load", 32'(reg_load), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_quiet",
          {product[30:0] | 31'(busy) | 31'(done), 1'b0},
          32'd0);
    end

    // 2, 3: basic and boundary operands
    op(16'd3, 16'd5);
    op(16'hFFFF, 16'hFFFF);
    op(16'h0000, 16'h1234);

    // 4: start while busy is ignored
    @(negedge clk);
    a = 16'd3;
    b = 16'd5;
    start = 1'b1;
    sb.push_back(32'h0000_000F);
    @(posedge clk);
    #1 start = 1'b0;
    e = cyc;
    repeat (3) @(posedge clk);
    #1;
    a = 16'd7;
    b = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 start = 1'b1;
    wait_done(t1);
    chk("ign_latency", 32'(t1 - e), 32'd16);
    chk("ign_product", product, pop_exp());
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ign_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("ign_hold", product, 32'h0000_000F);
      chk("ign_idle", 32'(busy), 32'd0);
    end

    // 5: reset mid-run discards the result
    @(negedge clk);
    a = 16'h1234;
    b = 16'h0010;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_product", product, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("mid_rst_nodone", 32'(done), 32'd0);
    end
    op(16'd2, 16'd9);

    // 6: back-to-back with start held high
    @(negedge clk);
    a = 16'd10;
    b = 16'd10;
    start = 1'b1;
    sb.push_back(32'h0000_0064);
    @(posedge clk);
    #1;
    wait_done(t1);
    chk("b2b_first", product, pop_exp());
    a = 16'h8000;
    b = 16'd2;
    sb.push_back(32'h0001_0000);
    @(posedge clk);
    #1;
    chk("b2b_dreg1", dreg, 32'h0000_0064);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(t2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd18);
    ex = pop_exp();
    chk("b2b_second", product, ex);
    @(negedge clk);
    chk("b2b_dreg2", dreg, ex);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
